// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: length encoding, canonical NOP and the
// registered output bundle handed to decode.
package rv_fetch_pkg;

  localparam logic [1:0]  RVC_LEN32 = 2'b11;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_rvc;
  } fetch_out_t;

  function automatic logic is_len32(input logic [15:0] h);
    return h[1:0] == RVC_LEN32;
  endfunction

endpackage

// File: rtl/ifu_aligner.sv
// Combinational realigner: picks the instruction at fetch_pc from the ROM word
// and the buffered upper halfword. Mixed 16/32-bit handling only with RVC_EN.
module ifu_aligner
  import rv_fetch_pkg::*;
(
  input  logic        pc_b1,
  input  logic [15:0] hbuf,
  input  logic        hbuf_vld,
  input  logic [31:0] imem_rdata,
  output logic        emit,
  output logic [31:0] instr,
  output logic        is_rvc,
  output logic [2:0]  pc_inc,
  output logic [15:0] hbuf_nxt,
  output logic        hbuf_vld_nxt
);

`ifdef RVC_EN
  always_comb begin
    emit         = 1'b1;
    instr        = imem_rdata;
    is_rvc       = 1'b0;
    pc_inc       = 3'd4;
    hbuf_nxt     = hbuf;
    hbuf_vld_nxt = 1'b0;
    if (!pc_b1) begin
      if (!is_len32(imem_rdata[15:0])) begin
        instr        = {16'h0, imem_rdata[15:0]};
        is_rvc       = 1'b1;
        pc_inc       = 3'd2;
        hbuf_nxt     = imem_rdata[31:16];
        hbuf_vld_nxt = 1'b1;
      end
    end else if (hbuf_vld) begin
      if (!is_len32(hbuf)) begin
        instr  = {16'h0, hbuf};
        is_rvc = 1'b1;
        pc_inc = 3'd2;
      end else begin
        // 32-bit instruction straddling the word boundary
        instr        = {imem_rdata[15:0], hbuf};
        hbuf_nxt     = imem_rdata[31:16];
        hbuf_vld_nxt = 1'b1;
      end
    end else begin
      if (!is_len32(imem_rdata[31:16])) begin
        instr  = {16'h0, imem_rdata[31:16]};
        is_rvc = 1'b1;
        pc_inc = 3'd2;
      end else begin
        // redirect into the upper half of a 32-bit op: buffer it, one bubble
        emit         = 1'b0;
        instr        = INSTR_NOP;
        pc_inc       = 3'd0;
        hbuf_nxt     = imem_rdata[31:16];
        hbuf_vld_nxt = 1'b1;
      end
    end
  end
`else
  logic unused_in;
  assign unused_in    = ^{pc_b1, hbuf, hbuf_vld};
  assign emit         = 1'b1;
  assign instr        = imem_rdata;
  assign is_rvc       = 1'b0;
  assign pc_inc       = 3'd4;
  assign hbuf_nxt     = 16'h0;
  assign hbuf_vld_nxt = 1'b0;
`endif

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, ROM addressing, redirect and the
// registered valid/ready output. Define RVC_EN for mixed 16/32-bit streams.
module if_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_is_rvc
);

`ifdef RVC_EN
  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(1);
`else
  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);
`endif

  logic [XLEN-1:0] fetch_pc;
  logic [15:0]     hbuf;
  logic            hbuf_vld;
  fetch_out_t      out_q;
  logic            advance;

  logic            al_emit;
  logic [31:0]     al_instr;
  logic            al_is_rvc;
  logic [2:0]      al_inc;
  logic [15:0]     al_hbuf_nxt;
  logic            al_hbuf_vld_nxt;

  assign advance = !if_valid || if_ready;

`ifdef RVC_EN
  assign imem_addr = {fetch_pc[XLEN-1:2], 2'b00}
                   + ((fetch_pc[1] && hbuf_vld) ? XLEN'(4) : XLEN'(0));
`else
  assign imem_addr = fetch_pc;
  assign hbuf      = 16'h0;
  assign hbuf_vld  = 1'b0;
  logic unused_hbuf;
  assign unused_hbuf = ^{al_hbuf_nxt, al_hbuf_vld_nxt};
`endif

  ifu_aligner u_aligner (
    .pc_b1        (fetch_pc[1]),
    .hbuf         (hbuf),
    .hbuf_vld     (hbuf_vld),
    .imem_rdata   (imem_rdata),
    .emit         (al_emit),
    .instr        (al_instr),
    .is_rvc       (al_is_rvc),
    .pc_inc       (al_inc),
    .hbuf_nxt     (al_hbuf_nxt),
    .hbuf_vld_nxt (al_hbuf_vld_nxt)
  );

  // Redirect outranks both advance and stall; a held output is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC & PC_MASK;
      if_valid <= 1'b0;
      out_q    <= '0;
`ifdef RVC_EN
      hbuf     <= 16'h0;
      hbuf_vld <= 1'b0;
`endif
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & PC_MASK;
      if_valid <= 1'b0;
`ifdef RVC_EN
      hbuf_vld <= 1'b0;
`endif
    end else if (advance) begin
      fetch_pc <= fetch_pc + XLEN'(al_inc);
      if_valid <= al_emit;
`ifdef RVC_EN
      hbuf     <= al_hbuf_nxt;
      hbuf_vld <= al_hbuf_vld_nxt;
`endif
      if (al_emit) begin
        out_q.instr  <= al_instr;
        out_q.pc     <= fetch_pc;
        out_q.is_rvc <= al_is_rvc;
      end
    end
  end

  assign if_instr  = out_q.instr;
  assign if_pc     = out_q.pc;
  assign if_is_rvc = out_q.is_rvc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; expectations follow the RVC_EN setting
// the design is compiled with.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_is_rvc;

  logic [31:0] rom [0:255];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr[9:2]];

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_ready       (if_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_is_rvc      (if_is_rvc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic rvc);
    chk({tag, "_vld"}, {31'h0, if_valid}, 32'h1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, instr);
    chk({tag, "_rvc"}, {31'h0, if_is_rvc}, {31'h0, rvc});
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    chk("redir_drop", {31'h0, if_valid}, 32'h0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !if_valid; i++) step();
    chk({tag, "_timeout"}, {31'h0, if_valid}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
`ifdef RVC_EN
    rom[0]    = 32'h4505_4501;
    rom[1]    = 32'h0093_4501;
    rom[2]    = 32'h4509_0050;
    rom[3]    = 32'h00A0_0113;
    rom[4]    = 32'h0020_0213;
    rom[8'h40] = 32'h0113_0001;
    rom[8'h41] = 32'h4501_00A0;
`else
    rom[0]    = 32'h0050_0093;
    rom[1]    = 32'h4505_4501;
    rom[2]    = 32'h00A0_0113;
    rom[8]    = 32'h0030_0293;
    rom[8'h41] = 32'h0010_0213;
    rom[8'h42] = 32'h0020_0213;
    rom[255]  = 32'hDEAD_0003;
`endif
    step(); step();
    chk("rst_vld", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_rvc", {31'h0, if_is_rvc}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    step();
`ifdef RVC_EN
    expect_out("c0", 32'h0, 32'h0000_4501, 1'b1);
    chk("c0_addr", imem_addr, 32'h4);
    step(); expect_out("c2", 32'h2, 32'h0000_4505, 1'b1);
    step(); expect_out("c4", 32'h4, 32'h0000_4501, 1'b1);
    step(); expect_out("strad6", 32'h6, 32'h0050_0093, 1'b0);
    step(); expect_out("cA", 32'hA, 32'h0000_4509, 1'b1);
    step(); expect_out("wC", 32'hC, 32'h00A0_0113, 1'b0);
    step(); expect_out("w10", 32'h10, 32'h0020_0213, 1'b0);
    // straddling redirect target: bubble, then joined word after N+2
    redirect(32'h0000_0102);
    step(); chk("c_bubble", {31'h0, if_valid}, 32'h0);
    step(); expect_out("r102", 32'h102, 32'h00A0_0113, 1'b0);
    step(); expect_out("r106", 32'h106, 32'h0000_4501, 1'b1);
    if_ready = 1'b0;
    step(); expect_out("stall1", 32'h106, 32'h0000_4501, 1'b1);
    redirect(32'h0000_0003);
    step(); wait_valid("stall_redir", 4);
    expect_out("r2", 32'h2, 32'h0000_4505, 1'b1);
    if_ready = 1'b1;
`else
    expect_out("w0", 32'h0, 32'h0050_0093, 1'b0);
    step(); expect_out("w4", 32'h4, 32'h4505_4501, 1'b0);
    if_ready = 1'b0;
    step(); expect_out("stall1", 32'h4, 32'h4505_4501, 1'b0);
    step(); expect_out("stall2", 32'h4, 32'h4505_4501, 1'b0);
    if_ready = 1'b1;
    step(); expect_out("w8", 32'h8, 32'h00A0_0113, 1'b0);
    redirect(32'h0000_0106);
    step(); expect_out("r104", 32'h104, 32'h0010_0213, 1'b0);
    step(); expect_out("r108", 32'h108, 32'h0020_0213, 1'b0);
    if_ready = 1'b0;
    step(); expect_out("stall3", 32'h108, 32'h0020_0213, 1'b0);
    redirect(32'h0000_0020);
    step(); wait_valid("stall_redir", 4);
    expect_out("r20", 32'h20, 32'h0030_0293, 1'b0);
    if_ready = 1'b1;
    redirect(32'hFFFF_FFFE);
    step(); expect_out("wrap_hi", 32'hFFFF_FFFC, 32'hDEAD_0003, 1'b0);
    step(); expect_out("wrap_lo", 32'h0, 32'h0050_0093, 1'b0);
`endif
    // reset wins over a simultaneous redirect
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0104;
    step();
    chk("rst_mid_vld", {31'h0, if_valid}, 32'h0);
    chk("rst_mid_addr", imem_addr, 32'h0);
    rst = 1'b0; redirect_valid = 1'b0;
    step();
    chk("rst_mid_pc", if_pc, 32'h0);
    chk("rst_mid_vld2", {31'h0, if_valid}, 32'h1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the RV32ICMFA pipeline. Owns the fetch PC, drives the word-aligned address of the combinational instruction ROM, and realigns mixed 16/32-bit instruction streams, including 32-bit instructions straddling a word boundary. Delivers one instruction per cycle to decode through a registered valid/ready output and accepts branch/jump redirects from execute.

## Interface
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset; bit 0 ignored.
- XLEN, 32: address/data width; only 32 supported.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  32  word-aligned ROM address, combinational from state
- imem_rdata  in  32  ROM word at imem_addr, same cycle
- redirect_valid  in  1  redirect request, sampled at clk edge
- redirect_pc  in  32  redirect target; bit 0 ignored
- if_ready  in  1  decode accepts the output this cycle
- if_valid  out  1  output register holds an instruction
- if_instr  out  32  raw instruction; for compressed, {16'h0, halfword}
- if_pc  out  32  address of if_instr
- if_is_rvc  out  1  if_instr is 16-bit

## Operation
- State: fetch_pc (halfword aligned), hbuf[15:0], hbuf_vld, output register.
- imem_addr = {fetch_pc[31:2],2'b00} + ((fetch_pc[1] & hbuf_vld) ? 4 : 0).
- advance = !if_valid | if_ready. Without advance, all state holds.
- Length rule: halfword h is 32-bit iff h[1:0]==2'b11, else compressed.
- On advance, one case applies:
  - A, fetch_pc[1]=0: w=imem_rdata. If compressed: emit w[15:0], pc+=2, hbuf<=w[31:16], hbuf_vld<=1. Else emit w, pc+=4, hbuf_vld<=0.
  - B, fetch_pc[1]=1, hbuf_vld=1: if hbuf is compressed, emit hbuf, pc+=2, hbuf_vld<=0. Else emit {imem_rdata[15:0],hbuf}, pc+=4, hbuf<=imem_rdata[31:16], hbuf_vld<=1.
  - C, fetch_pc[1]=1, hbuf_vld=0 (only after a redirect): h=imem_rdata[31:16]. If compressed, emit h, pc+=2. Else hbuf<=h, hbuf_vld<=1, if_valid<=0 (one bubble), pc unchanged.
- Emitting loads if_instr/if_pc/if_is_rvc and sets if_valid. A non-emitting advance clears if_valid.
- Redirect has top priority over advance and stall. It sets fetch_pc<={redirect_pc[31:1],1'b0}, hbuf_vld<=0, if_valid<=0. Any held output is discarded, even if if_ready is low.
- PC arithmetic is modulo 2^32. Wrap from 32'hFFFF_FFFE is legal and unchecked.
- No illegal-instruction detection; decode owns that.

## Timing
- Reset: if_valid=0, if_instr=0, if_pc=0, if_is_rvc=0, hbuf_vld=0, fetch_pc=RESET_PC. imem_addr reflects RESET_PC during reset.
- First instruction has if_valid=1 after the first edge with rst=0.
- Redirect sampled at edge N gives if_valid=1 with if_pc=redirect target after edge N+1. A straddling 32-bit target (case C) appears after edge N+2.
- Steady state is one instruction per cycle, with no bubbles for any 16/32 mix.
- Stall: outputs stable while if_valid & !if_ready.
- Reset asserted mid-stream overrides redirect and discards everything.

## Configuration
- RVC_EN defined: full 16/32-bit behaviour as above.
- RVC_EN undefined:
  - hbuf, hbuf_vld and cases B/C are removed.
  - fetch_pc is word aligned; redirect_pc[1:0] and RESET_PC[1:0] are ignored.
  - imem_addr = fetch_pc. Every word is emitted as 32-bit with pc+=4.
  - if_is_rvc tied 0. Redirect latency is always 1 cycle.

## Structure
- Shared package rv_fetch_pkg holds: RVC_LEN32 = 2'b11, INSTR_NOP = 32'h0000_0013, and the fetch output bundle typedef {instr, pc, is_rvc}.
- One sub-module, ifu_aligner: combinational.
  - Inputs: fetch_pc[1], hbuf, hbuf_vld, imem_rdata.
  - Outputs: emit, instr, is_rvc, pc increment (0/2/4), next hbuf and hbuf_vld.
- The top holds registers, handshake, redirect and address generation.

## Test plan
- Reset with RESET_PC=0, ROM word0=32'h00500093 -> after rst release, if_valid=1, if_pc=0, if_instr=32'h00500093, if_is_rvc=0; next if_pc=4.
- ROM word0=32'h4505_4501 (two c.li) -> if_pc 0 then 2, if_is_rvc=1, if_instr 32'h4501 then 32'h4505; imem_addr then advances to 4.
- Straddle: word0=32'h0093_4501, word1=32'h????_0050 -> c.li @0, then if_instr=32'h00500093 @2, is_rvc=0, next if_pc=6, no bubble.
- Redirect to 32'h0000_0102 where the halfword at 0x102 is 32-bit -> one bubble cycle, then if_pc=0x102 with the correct joined word, after edge N+2.
- Hold if_ready=0 for 3 cycles with redirect_valid pulsed in cycle 2 -> the stalled output is dropped, and the next valid if_pc equals the redirect target.
- RVC_EN undefined, redirect_pc=32'h0000_0106 -> if_pc=0x104, if_is_rvc=0, sequence 0x104, 0x108.
